// File: rtl/arbitro_compuerta.sv
// arbitro_compuerta: round-robin arbiter that lets two entry lanes (A, B)
// share one gate controller. The granted lane's sensor/keypad inputs are
// forwarded to the gate with one cycle of latency. The grant is released
// after the gate has opened and closed again, when the vehicle leaves
// before the gate opens, or after an inactivity timeout.
module arbitro_compuerta #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5,
    localparam int unsigned PIN_W  = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Vehiculo_A,
    input  logic             Vehiculo_B,
    input  logic [PIN_W-1:0] Pin_A,
    input  logic [PIN_W-1:0] Pin_B,
    input  logic             enterPin_A,
    input  logic             enterPin_B,
    input  logic             Termino_A,
    input  logic             Termino_B,
    input  logic             Cerrado,
    input  logic             Abierto,
    input  logic             Alarma,
    input  logic             Bloqueo,
    output logic             Vehiculo,
    output logic             Termino,
    output logic             enterPin,
    output logic [PIN_W-1:0] Pin,
    output logic             Grant_A,
    output logic             Grant_B,
    output logic             Espera_A,
    output logic             Espera_B,
    output logic             Timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             LANE_A   = 1'b0;
    localparam logic             LANE_B   = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVICIO = 2'd1,
        LIBERAR  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic              seen_q, seen_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              veh_d, ter_d, ep_d;
    logic [PIN_W-1:0]  pin_d;
    logic              grant_a_d, grant_b_d;
    logic              espera_a_d, espera_b_d;
    logic              timeout_d;

    logic              lane_veh;
    logic              blk;
    logic              done;
    logic              abandon;
    logic              expire;

    // Release conditions of the lane currently being served
    always_comb begin
        lane_veh = (sel_q == LANE_B) ? Vehiculo_B : Vehiculo_A;
        blk      = Bloqueo | Alarma;
        done     = seen_q & Cerrado & ~Bloqueo;
        abandon  = ~lane_veh & ~seen_q;
        expire   = (cnt_q == CNT_LAST) & ~seen_q & ~Abierto & ~enterPin;
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            sel_q    <= LANE_A;
            last_q   <= LANE_B;
            seen_q   <= 1'b0;
            cnt_q    <= '0;
            Vehiculo <= 1'b0;
            Termino  <= 1'b0;
            enterPin <= 1'b0;
            Pin      <= '0;
            Grant_A  <= 1'b0;
            Grant_B  <= 1'b0;
            Espera_A <= 1'b0;
            Espera_B <= 1'b0;
            Timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            seen_q   <= seen_d;
            cnt_q    <= cnt_d;
            Vehiculo <= veh_d;
            Termino  <= ter_d;
            enterPin <= ep_d;
            Pin      <= pin_d;
            Grant_A  <= grant_a_d;
            Grant_B  <= grant_b_d;
            Espera_A <= espera_a_d;
            Espera_B <= espera_b_d;
            Timeout  <= timeout_d;
        end
    end

    // Next state, lane selection, inactivity counter and gate-opened flag
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                seen_d = 1'b0;
                if (Vehiculo_A | Vehiculo_B) begin
                    state_d = SERVICIO;
                    if (Vehiculo_A & Vehiculo_B) begin
                        sel_d = ~last_q;
                    end else begin
                        sel_d = Vehiculo_B ? LANE_B : LANE_A;
                    end
                end
            end
            SERVICIO: begin
                if (Abierto) begin
                    seen_d = 1'b1;
                end
                // Saturate so a long open gate cannot wrap back into a timeout
                if (enterPin) begin
                    cnt_d = '0;
                end else if (!blk && !Abierto && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A blocked or alarmed gate keeps the grant no matter what
                if (!blk && (done || abandon || expire)) begin
                    state_d = LIBERAR;
                end
            end
            LIBERAR: begin
                last_d  = sel_q;
                cnt_d   = '0;
                seen_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        veh_d      = 1'b0;
        ter_d      = 1'b0;
        ep_d       = 1'b0;
        pin_d      = '0;
        grant_a_d  = 1'b0;
        grant_b_d  = 1'b0;
        espera_a_d = 1'b0;
        espera_b_d = 1'b0;
        timeout_d  = 1'b0;

        if (state_d == SERVICIO) begin
            grant_a_d = (sel_d == LANE_A);
            grant_b_d = (sel_d == LANE_B);
        end

        // Forward only while service continues; the other lane never leaks through
        if (state_q == SERVICIO && state_d == SERVICIO) begin
            if (sel_q == LANE_B) begin
                veh_d = Vehiculo_B;
                ter_d = Termino_B;
                ep_d  = enterPin_B;
                pin_d = Pin_B;
            end else begin
                veh_d = Vehiculo_A;
                ter_d = Termino_A;
                ep_d  = enterPin_A;
                pin_d = Pin_A;
            end
        end

        espera_a_d = Vehiculo_A & ~grant_a_d;
        espera_b_d = Vehiculo_B & ~grant_b_d;

        // Completion and abandon take precedence over a timeout in the same cycle
        timeout_d = (state_q == SERVICIO) & ~blk & ~done & ~abandon & expire;
    end

endmodule

// File: tb/tb_arbitro_compuerta.sv
// Bench for arbitro_compuerta: directed vector table plus hand-written
// sequences for timeout, block/alarm hold, abandon and asynchronous reset.
module tb_arbitro_compuerta;

    logic       Clk;
    logic       Reset;
    logic       Vehiculo_A, Vehiculo_B;
    logic [7:0] Pin_A, Pin_B;
    logic       enterPin_A, enterPin_B;
    logic       Termino_A, Termino_B;
    logic       Cerrado, Abierto, Alarma, Bloqueo;
    logic       Vehiculo, Termino, enterPin;
    logic [7:0] Pin;
    logic       Grant_A, Grant_B, Espera_A, Espera_B, Timeout;

    int checks   = 0;
    int failures = 0;

    arbitro_compuerta #(.TIMEOUT(16), .CNT_W(5)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Vehiculo_A (Vehiculo_A),
        .Vehiculo_B (Vehiculo_B),
        .Pin_A      (Pin_A),
        .Pin_B      (Pin_B),
        .enterPin_A (enterPin_A),
        .enterPin_B (enterPin_B),
        .Termino_A  (Termino_A),
        .Termino_B  (Termino_B),
        .Cerrado    (Cerrado),
        .Abierto    (Abierto),
        .Alarma     (Alarma),
        .Bloqueo    (Bloqueo),
        .Vehiculo   (Vehiculo),
        .Termino    (Termino),
        .enterPin   (enterPin),
        .Pin        (Pin),
        .Grant_A    (Grant_A),
        .Grant_B    (Grant_B),
        .Espera_A   (Espera_A),
        .Espera_B   (Espera_B),
        .Timeout    (Timeout)
    );

    // Posedges at 10, 20, ...; reset edges at 5 and 15 fall between them
    initial begin
        Clk = 1'b1;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic       va, vb;
        logic [7:0] pa, pb;
        logic       ea, eb, ta, tb, cer, abi;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[16];

    // Expected output word: {Grant_A,Grant_B,Espera_A,Espera_B,Vehiculo,enterPin,Termino,Timeout,Pin}
    function automatic logic [15:0] e(input logic ga, input logic gb, input logic wa, input logic wb,
                                      input logic veh, input logic ep, input logic ter, input logic to,
                                      input logic [7:0] p);
        return {ga, gb, wa, wb, veh, ep, ter, to, p};
    endfunction

    function automatic logic [15:0] outs();
        return {Grant_A, Grant_B, Espera_A, Espera_B, Vehiculo, enterPin, Termino, Timeout, Pin};
    endfunction

    function automatic vec_t mkv(input logic va, input logic vb, input logic [7:0] pa, input logic [7:0] pb,
                                 input logic ea, input logic eb, input logic ta, input logic tb,
                                 input logic cer, input logic abi, input logic [15:0] exp);
        vec_t v;
        v.va = va; v.vb = vb; v.pa = pa; v.pb = pb;
        v.ea = ea; v.eb = eb; v.ta = ta; v.tb = tb;
        v.cer = cer; v.abi = abi; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        Vehiculo_A = 0; Vehiculo_B = 0; Pin_A = 0; Pin_B = 0;
        enterPin_A = 0; enterPin_B = 0; Termino_A = 0; Termino_B = 0;
        Cerrado = 0; Abierto = 0; Alarma = 0; Bloqueo = 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        zero_inputs();
        Reset = 1'b1;
        #5  Reset = 1'b0;
        #10 Reset = 1'b1;
        #1;
        chk("reset_outputs", outs(), 16'h0000);

        // Lane A alone, then both lanes twice to show alternation
        tbl[0]  = mkv(1,0,8'h00,8'h00,0,0,0,0,0,0, e(1,0,0,0,0,0,0,0,8'h00));
        tbl[1]  = mkv(1,0,8'h10,8'h00,1,0,0,0,0,0, e(1,0,0,0,1,1,0,0,8'h10));
        tbl[2]  = mkv(1,0,8'h10,8'h00,0,0,0,0,0,1, e(1,0,0,0,1,0,0,0,8'h10));
        tbl[3]  = mkv(1,0,8'h10,8'h00,0,0,1,0,0,1, e(1,0,0,0,1,0,1,0,8'h10));
        tbl[4]  = mkv(0,0,8'h10,8'h00,0,0,0,0,1,0, e(0,0,0,0,0,0,0,0,8'h00));
        tbl[5]  = mkv(0,0,8'h00,8'h00,0,0,0,0,1,0, e(0,0,0,0,0,0,0,0,8'h00));
        tbl[6]  = mkv(1,1,8'h00,8'h00,0,0,0,0,0,0, e(0,1,1,0,0,0,0,0,8'h00));
        tbl[7]  = mkv(1,1,8'h55,8'h22,1,1,0,0,0,0, e(0,1,1,0,1,1,0,0,8'h22));
        tbl[8]  = mkv(1,1,8'h55,8'h22,0,0,0,0,0,1, e(0,1,1,0,1,0,0,0,8'h22));
        tbl[9]  = mkv(1,1,8'h55,8'h22,0,0,0,0,1,0, e(0,0,1,1,0,0,0,0,8'h00));
        tbl[10] = mkv(1,1,8'h55,8'h22,0,0,0,0,1,0, e(0,0,1,1,0,0,0,0,8'h00));
        tbl[11] = mkv(1,1,8'h55,8'h22,0,0,0,0,0,0, e(1,0,0,1,0,0,0,0,8'h00));
        tbl[12] = mkv(1,1,8'h55,8'h22,0,0,0,0,0,1, e(1,0,0,1,1,0,0,0,8'h55));
        tbl[13] = mkv(1,1,8'h55,8'h22,0,0,0,0,1,0, e(0,0,1,1,0,0,0,0,8'h00));
        tbl[14] = mkv(0,0,8'h00,8'h00,0,0,0,0,0,0, e(0,0,0,0,0,0,0,0,8'h00));
        tbl[15] = mkv(0,0,8'h00,8'h00,0,0,0,0,0,0, e(0,0,0,0,0,0,0,0,8'h00));

        for (int i = 0; i < 16; i++) begin
            Vehiculo_A = tbl[i].va;  Vehiculo_B = tbl[i].vb;
            Pin_A      = tbl[i].pa;  Pin_B      = tbl[i].pb;
            enterPin_A = tbl[i].ea;  enterPin_B = tbl[i].eb;
            Termino_A  = tbl[i].ta;  Termino_B  = tbl[i].tb;
            Cerrado    = tbl[i].cer; Abierto    = tbl[i].abi;
            tick();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Timeout on lane B: 16 idle cycles, last_served is A here
        zero_inputs();
        Vehiculo_B = 1;
        tick();
        chk("to_grant_b", 16'(Grant_B), 16'd1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("to_wait%0d", i), 16'({Grant_B, Timeout}), 16'b10);
        end
        tick();
        chk("to_pulse", 16'({Grant_B, Timeout, Espera_B}), 16'b011);
        tick();
        chk("to_after", 16'({Grant_B, Timeout, Espera_B}), 16'b001);
        tick();
        chk("to_regrant_single", 16'(Grant_B), 16'd1);
        // enterPin at cycle 10 restarts the idle count; expiry moves to cycle 27
        for (int i = 1; i <= 26; i++) begin
            enterPin_B = (i == 10);
            tick();
            chk($sformatf("to_pin_wait%0d", i), 16'({Grant_B, Timeout}), 16'b10);
        end
        enterPin_B = 0;
        tick();
        chk("to_pin_pulse", 16'({Grant_B, Timeout}), 16'b01);
        Vehiculo_B = 0;
        tick();
        chk("to_pin_after", 16'({Grant_B, Timeout}), 16'b00);
        tick();

        // Block/alarm hold on lane A, including a vehicle drop while blocked
        Vehiculo_A = 1;
        tick();
        chk("blk_grant_a", 16'(Grant_A), 16'd1);
        Bloqueo = 1;
        for (int i = 0; i < 40; i++) begin
            Vehiculo_A = !(i >= 20 && i < 25);
            tick();
            chk($sformatf("blk_hold%0d", i), 16'({Grant_A, Timeout}), 16'b10);
        end
        Vehiculo_A = 1;
        Bloqueo = 0;
        Alarma = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("alm_hold%0d", i), 16'({Grant_A, Timeout}), 16'b10);
        end
        Alarma = 0;
        Abierto = 1;
        tick();
        chk("blk_open", 16'({Grant_A, Vehiculo}), 16'b11);
        Abierto = 0;
        Cerrado = 1;
        Bloqueo = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("blk_closed_hold%0d", i), 16'(Grant_A), 16'd1);
        end
        Bloqueo = 0;
        tick();
        chk("blk_release", 16'({Grant_A, Timeout}), 16'b00);
        Cerrado = 0;
        Vehiculo_A = 0;
        tick();

        // Abandon on lane A with B pending; lane-A inputs must not leak
        Vehiculo_A = 1;
        tick();
        chk("ab_grant_a", 16'(Grant_A), 16'd1);
        Vehiculo_B = 1;
        tick();
        chk("ab_wait_b", 16'({Grant_A, Grant_B, Espera_B, Vehiculo}), 16'b1011);
        Vehiculo_A = 0;
        tick();
        chk("ab_release", 16'({Grant_A, Grant_B, Espera_B, Vehiculo}), 16'b0010);
        Vehiculo_A = 1; Pin_A = 8'hAA; enterPin_A = 1; Termino_A = 1;
        tick();
        chk("ab_idle", outs(), e(0,0,1,1,0,0,0,0,8'h00));
        tick();
        chk("ab_grant_b", outs(), e(0,1,1,0,0,0,0,0,8'h00));
        Vehiculo_A = 0; Pin_B = 8'h3C;
        tick();
        chk("ab_fwd_b", outs(), e(0,1,0,0,1,0,0,0,8'h3C));
        zero_inputs();
        tick();
        chk("ab_b_gone", outs(), 16'h0000);
        tick();

        // Async reset mid-service after lane A was served last
        Vehiculo_A = 1;
        tick();
        Vehiculo_A = 0;
        tick();
        tick();
        Vehiculo_B = 1;
        tick();
        chk("rst_grant_b", 16'(Grant_B), 16'd1);
        Abierto = 1;
        tick();
        chk("rst_fwd_b", 16'({Grant_B, Vehiculo}), 16'b11);
        Vehiculo_A = 1;
        @(negedge Clk);
        #1 Reset = 1'b0;
        #1;
        chk("rst_async", outs(), 16'h0000);
        tick();
        chk("rst_held", outs(), 16'h0000);
        @(negedge Clk);
        Reset = 1'b1;
        Abierto = 0;
        tick();
        chk("rst_tie_a", outs(), e(1,0,0,1,0,0,0,0,8'h00));

        zero_inputs();
        tick();
        tick();
        tick();
        chk("end_idle", 16'({Grant_A, Grant_B}), 16'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
